// File: rtl/sipo_rx.sv
// sipo_rx: serial-in parallel-out receiver with sof framing,
// a registered valid/ready output stage and a sticky overrun flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   sin        serial data bit
//   sin_valid  qualifies sin and sof on this edge
//   sof        start of frame: current bit becomes bit 0 of a word
//   pout       assembled word (registered)
//   pout_valid pout holds an unconsumed word
//   pout_ready downstream accepts pout when pout_valid is also high
//   busy       a partial word is being assembled
//   bit_cnt    bits collected in the current partial word
//   overrun    sticky: a completed word was dropped
//   ovr_clr    synchronous clear of overrun
module sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun,
    input  logic             ovr_clr
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pv_q, pv_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first;
    logic             complete;
    logic             ovr_set;

    // Word with the current bit appended, and a fresh word holding
    // only the current bit (used on sof).
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shreg_q[WIDTH-2:0], sin};
            first   = {{(WIDTH-1){1'b0}}, sin};
        end else begin
            shifted = {sin, shreg_q[WIDTH-1:1]};
            first   = {sin, {(WIDTH-1){1'b0}}};
        end
    end

    // sof on the last bit position is a restart, never a completion.
    assign complete = (state_q == SHIFT) && sin_valid && !sof
                      && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        pout_d  = pout_q;
        pv_d    = pv_q;
        ovr_d   = ovr_q;
        ovr_set = 1'b0;

        if (sin_valid && sof) begin
            state_d = SHIFT;
            shreg_d = first;
            cnt_d   = CW'(1);
        end else if (sin_valid && state_q == SHIFT) begin
            if (complete) begin
                state_d = IDLE;
                shreg_d = shifted;
                cnt_d   = '0;
            end else begin
                shreg_d = shifted;
                cnt_d   = cnt_q + CW'(1);
            end
        end

        if (pv_q && pout_ready) begin
            pv_d = 1'b0;
        end

        // A word can be loaded if the slot is empty or freed this edge.
        if (complete) begin
            if (!pv_q || pout_ready) begin
                pout_d = shifted;
                pv_d   = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end

        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            pout_q  <= '0;
            pv_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            pout_q  <= pout_d;
            pv_q    <= pv_d;
            ovr_q   <= ovr_d;
        end
    end

    assign pout       = pout_q;
    assign pout_valid = pv_q;
    assign busy       = (state_q == SHIFT);
    assign bit_cnt    = cnt_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: directed test of sipo_rx, WIDTH=4, with an MSB-first
// and an LSB-first instance sharing the same stimulus.
module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       sof = 1'b0;
    logic       pout_ready = 1'b0;
    logic       ovr_clr = 1'b0;

    logic [3:0] pout_m, pout_l;
    logic       pv_m, pv_l;
    logic       busy_m, busy_l;
    logic [1:0] cnt_m, cnt_l;
    logic       ovr_m, ovr_l;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
        .sof(sof), .pout(pout_m), .pout_valid(pv_m),
        .pout_ready(pout_ready), .busy(busy_m), .bit_cnt(cnt_m),
        .overrun(ovr_m), .ovr_clr(ovr_clr)
    );

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
        .sof(sof), .pout(pout_l), .pout_valid(pv_l),
        .pout_ready(pout_ready), .busy(busy_l), .bit_cnt(cnt_l),
        .overrun(ovr_l), .ovr_clr(ovr_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic s);
        sin_valid = 1'b1;
        sin = b;
        sof = s;
        tick();
        sin_valid = 1'b0;
        sof = 1'b0;
    endtask

    task automatic idle();
        sin_valid = 1'b0;
        tick();
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_pout", pout_m, 4'b0000);
        chk("rst_pv", pv_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_cnt", cnt_m, 2'd0);
        chk("rst_ovr", ovr_m, 1'b0);
        rst = 1'b0;
        idle();

        // basic 1,0,1,1
        pout_ready = 1'b1;
        send(1'b1, 1'b1);
        chk("b_cnt1", cnt_m, 2'd1);
        chk("b_busy1", busy_m, 1'b1);
        chk("b_pv1", pv_m, 1'b0);
        send(1'b0, 1'b0);
        chk("b_cnt2", cnt_m, 2'd2);
        send(1'b1, 1'b0);
        chk("b_cnt3", cnt_m, 2'd3);
        chk("b_busy3", busy_m, 1'b1);
        send(1'b1, 1'b0);
        chk("b_pout", pout_m, 4'b1011);
        chk("b_pv", pv_m, 1'b1);
        chk("b_cnt0", cnt_m, 2'd0);
        chk("b_busy0", busy_m, 1'b0);
        chk("l_pout", pout_l, 4'b1101);
        chk("l_pv", pv_l, 1'b1);
        idle();
        chk("b_pv_drop", pv_m, 1'b0);
        chk("b_pout_hold", pout_m, 4'b1011);

        // stray bits and gaps, word 0110
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        chk("g_stray_busy", busy_m, 1'b0);
        chk("g_stray_cnt", cnt_m, 2'd0);
        send(1'b0, 1'b1);
        idle();
        send(1'b1, 1'b0);
        idle();
        idle();
        chk("g_cnt_gap", cnt_m, 2'd2);
        send(1'b1, 1'b0);
        idle();
        chk("g_pv_mid", pv_m, 1'b0);
        send(1'b0, 1'b0);
        chk("g_pout", pout_m, 4'b0110);
        chk("g_pv", pv_m, 1'b1);
        idle();

        // backpressure and overrun
        pout_ready = 1'b0;
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        chk("o_pout1", pout_m, 4'b1110);
        chk("o_ovr0", ovr_m, 1'b0);
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        chk("o_pout_kept", pout_m, 4'b1110);
        chk("o_ovr1", ovr_m, 1'b1);
        chk("o_pv", pv_m, 1'b1);
        pout_ready = 1'b1;
        idle();
        pout_ready = 1'b0;
        chk("o_pv_hs", pv_m, 1'b0);
        chk("o_ovr_sticky", ovr_m, 1'b1);
        ovr_clr = 1'b1;
        idle();
        ovr_clr = 1'b0;
        chk("o_ovr_clr", ovr_m, 1'b0);

        // simultaneous handshake and completion
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        chk("s_pend", pout_m, 4'b1110);
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        pout_ready = 1'b1;
        send(1'b0, 1'b0);
        pout_ready = 1'b0;
        chk("s_pout", pout_m, 4'b1010);
        chk("s_pv", pv_m, 1'b1);
        chk("s_ovr", ovr_m, 1'b0);

        // overrun set wins over clear on the same edge
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        ovr_clr = 1'b1;
        send(1'b1, 1'b0);
        ovr_clr = 1'b0;
        chk("w_ovr", ovr_m, 1'b1);
        chk("w_pout", pout_m, 4'b1010);
        ovr_clr = 1'b1;
        pout_ready = 1'b1;
        idle();
        ovr_clr = 1'b0;
        chk("w_ovr_clr", ovr_m, 1'b0);
        chk("w_pv", pv_m, 1'b0);

        // resync after 2 bits, word 0101
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        chk("r_cnt2", cnt_m, 2'd2);
        send(1'b0, 1'b1);
        chk("r_cnt1", cnt_m, 2'd1);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        chk("r_pout", pout_m, 4'b0101);
        chk("r_ovr", ovr_m, 1'b0);
        idle();

        // sof on the 4th bit restarts instead of completing
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        chk("f_cnt", cnt_m, 2'd1);
        chk("f_pv", pv_m, 1'b0);
        chk("f_pout", pout_m, 4'b0101);
        pout_ready = 1'b0;
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        chk("f_pout2", pout_m, 4'b1001);
        chk("f_pv2", pv_m, 1'b1);

        // overrun, then a partial word, then async reset
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        chk("x_ovr", ovr_m, 1'b1);
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        chk("x_busy", busy_m, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("x_pout", pout_m, 4'b0000);
        chk("x_pv", pv_m, 1'b0);
        chk("x_busy0", busy_m, 1'b0);
        chk("x_cnt", cnt_m, 2'd0);
        chk("x_ovr0", ovr_m, 1'b0);
        chk("x_pv_l", pv_l, 1'b0);
        tick();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
